// File: rtl/window_ctrl_pkg.sv
// window_ctrl_pkg: shared state encoding and widths for the 3x3 window sequencer.
package window_ctrl_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int BIT_DEPTH = 8;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_ROW_END = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
endpackage

// File: rtl/window_ctrl_pos_counter.sv
// pos_counter: column/row position counters with terminal-count flags.
module pos_counter
    import window_ctrl_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             col_inc,
    input  logic             row_end,
    output logic [CNT_W-1:0] col_cnt,
    output logic [CNT_W-1:0] row_cnt,
    output logic             col_last,
    output logic             row_last
);
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    assign col_last = col_q == CNT_W'(IMG_W);
    assign row_last = row_q == CNT_W'(IMG_H - 3);
    assign col_cnt  = col_q;
    assign row_cnt  = row_q;
    always_comb begin
        col_d = (clr | row_end) ? '0 : col_q + CNT_W'(col_inc);
        row_d = clr ? '0 : (row_end & ~row_last) ? row_q + 1'b1 : row_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/window_ctrl.sv
// window_ctrl: sequences column shifts into a 3x3 window register and hands windows downstream.
module window_ctrl
    import window_ctrl_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_sft_en,
    output logic             win_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] col_cnt,
    output logic [CNT_W-1:0] row_cnt,
    output logic             row_adv,
    output logic             frame_done,
    output logic             busy
);
    logic [2:0] state_q, state_d;
    logic       win_valid_q, win_valid_d, row_adv_q, frame_done_q;
    logic       col_last, row_last;
    pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == S_IDLE && start),
        .col_inc  (wr_sft_en),
        .row_end  (state_q == S_ROW_END),
        .col_cnt  (col_cnt),
        .row_cnt  (row_cnt),
        .col_last (col_last),
        .row_last (row_last)
    );
    // Never shift over a window the consumer has not taken yet.
    assign in_ready   = (state_q == S_FILL) ||
                        (state_q == S_STREAM && !col_last && (!win_valid_q || out_ready));
    assign wr_sft_en  = in_valid & in_ready;
    assign win_valid  = win_valid_q;
    assign row_adv    = row_adv_q;
    assign frame_done = frame_done_q;
    assign busy       = state_q != S_IDLE;
    always_comb begin
        state_d     = state_q;
        win_valid_d = (state_q == S_STREAM) && (wr_sft_en || (win_valid_q && !out_ready));
        case (state_q)
            S_IDLE:    state_d = start ? S_FILL : S_IDLE;
            S_FILL:    state_d = (wr_sft_en && col_cnt == CNT_W'(1)) ? S_STREAM : S_FILL;
            S_STREAM:  state_d = (col_last && !win_valid_q) ? S_ROW_END : S_STREAM;
            S_ROW_END: state_d = row_last ? S_DONE : S_FILL;
            default:   state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            win_valid_q  <= 1'b0;
            row_adv_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_valid_q  <= win_valid_d;
            row_adv_q    <= state_d == S_ROW_END;
            frame_done_q <= state_d == S_DONE;
        end
    end
endmodule

// File: tb/tb_window_ctrl.sv
// tb_window_ctrl: scoreboard bench for window_ctrl with a 3x3 window register model beside it.
module tb_window_ctrl;
    import window_ctrl_pkg::*;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int CNT_W = 8;
    localparam int N_WIN = (IMG_W - 2) * (IMG_H - 2);
    typedef logic [BIT_DEPTH-1:0] pix_t;
    typedef logic [9*BIT_DEPTH-1:0] win_t;

    logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 1;
    logic in_ready, wr_sft_en, win_valid, row_adv, frame_done, busy;
    logic [CNT_W-1:0] col_cnt, row_cnt;
    pix_t in_l [3];
    pix_t w [3][3];
    win_t wq[$];
    int errors = 0, checks = 0;
    int n_win = 0, n_adv = 0, n_done = 0, n_sft = 0;
    int stall_len = 0, stall_gen = 0;

    window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .wr_sft_en(wr_sft_en), .win_valid(win_valid), .out_ready(out_ready),
        .col_cnt(col_cnt), .row_cnt(row_cnt), .row_adv(row_adv),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (wr_sft_en) begin
            for (int l = 0; l < 3; l++) begin
                w[l][2] <= w[l][1];
                w[l][1] <= w[l][0];
                w[l][0] <= in_l[l];
            end
        end
    end

    function automatic pix_t pix(input int r, input int k, input int l);
        return pix_t'(100 * r + 10 * k + l + 1);
    endfunction

    function automatic win_t exp_win(input int r, input int k);
        win_t v = '0;
        for (int l = 0; l < 3; l++)
            v = {v[6*BIT_DEPTH-1:0], pix(r, k, l), pix(r, k - 1, l), pix(r, k - 2, l)};
        return v;
    endfunction

    function automatic win_t cur_win();
        win_t v = '0;
        for (int l = 0; l < 3; l++)
            v = {v[6*BIT_DEPTH-1:0], w[l][0], w[l][1], w[l][2]};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input win_t act, input win_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Consumer: holds out_ready low for stall_len cycles on the first window after each new request.
    initial begin
        int seen = 0, rem = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_gen != seen) begin
                seen = stall_gen;
                rem = stall_len;
            end
            if (win_valid && rem > 0) begin
                out_ready = 0;
                rem--;
            end else out_ready = 1;
        end
    end

    // Monitor: pops expected windows on consumption and checks stall/handshake rules.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_sft_en) n_sft++;
                chk("sft_en_eq", 32'(wr_sft_en), 32'(in_valid & in_ready));
                if (win_valid && !out_ready) begin
                    chk("stall_in_ready", 32'(in_ready), 0);
                    if (wq.size() > 0) chk_win("stall_window_held", cur_win(), wq[0]);
                end
                if (win_valid && out_ready) begin
                    n_win++;
                    if (wq.size() == 0) chk("unexpected_window", 1, 0);
                    else chk_win("window", cur_win(), wq.pop_front());
                end
                if (row_adv) n_adv++;
                if (frame_done) n_done++;
                if (row_adv && frame_done) chk("adv_done_overlap", 1, 0);
            end
        end
    end

    task automatic send_col(input int r, input int k, input bit gap);
        bit acc = 0;
        for (int l = 0; l < 3; l++) in_l[l] = pix(r, k, l);
        if (gap) begin
            in_valid = 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(acc), 1);
        if (acc) begin
            if (k >= 2) wq.push_back(exp_win(r, k));
            chk("col_cnt", 32'(col_cnt), 32'(k + 1));
            chk("row_cnt", 32'(row_cnt), 32'(r));
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_sft"}, 32'(wr_sft_en), 0);
        chk({tag, "_win_valid"}, 32'(win_valid), 0);
        chk({tag, "_col"}, 32'(col_cnt), 0);
        chk({tag, "_row"}, 32'(row_cnt), 0);
        chk({tag, "_row_adv"}, 32'(row_adv), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
    endtask

    task automatic run_frame(input bit gap, input int stall, input bit poke,
                             input int abort_r, input int abort_k);
        int b_win = n_win, b_adv = n_adv, b_done = n_done, b_sft = n_sft;
        bit got = 0;
        stall_len = stall;
        stall_gen++;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        chk("busy_after_start", 32'(busy), 1);
        for (int r = 0; r <= IMG_H - 3; r++) begin
            for (int k = 0; k < IMG_W; k++) begin
                if (r == abort_r && k == abort_k) begin
                    in_valid = 0;
                    chk("abort_col", 32'(col_cnt), 32'(k));
                    rst = 1;
                    @(posedge clk);
                    #1;
                    rst = 0;
                    wq.delete();
                    chk_idle("abort");
                    return;
                end
                if (poke && r == 0 && k == 3) start = 1;
                send_col(r, k, gap);
                start = 0;
            end
        end
        in_valid = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1;
                if (poke) start = 1;
            end
            @(posedge clk);
            #1;
            start = 0;
        end
        chk("frame_done_seen", 32'(got), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("busy_after_frame", 32'(busy), 0);
        chk("windows", 32'(n_win - b_win), 32'(N_WIN));
        chk("row_adv_pulses", 32'(n_adv - b_adv), 32'(IMG_H - 2));
        chk("frame_done_pulses", 32'(n_done - b_done), 1);
        chk("shifts", 32'(n_sft - b_sft), 32'(IMG_W * (IMG_H - 2)));
        chk("queue_empty", 32'(wq.size()), 0);
    endtask

    initial begin
        for (int l = 0; l < 3; l++) in_l[l] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk_idle("reset");
        run_frame(0, 0, 0, -1, -1);
        run_frame(0, 4, 0, -1, -1);
        run_frame(1, 0, 0, -1, -1);
        run_frame(0, 0, 0, 1, 3);
        run_frame(0, 0, 0, -1, -1);
        run_frame(0, 0, 1, -1, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/window_ctrl.md
Name: window_ctrl

Overview:
Sequencer for the 3x3 sliding-window register (three line inputs, shift-enabled 3-column shift register). Accepts one column of three vertically aligned pixels per handshake and drives the window shift enable. Flags when the window holds a valid 3x3 neighbourhood and stalls upstream while a window awaits consumption. Tracks column/row position, requests line-buffer row advance at row end, and signals frame completion.

Parameters:
IMG_W, 28, image width in pixels (columns shifted per row); legal range >= 3
IMG_H, 28, image height in lines; legal range >= 3; output rows = IMG_H-2
CNT_W, 8, width of column/row counters; must satisfy 2^CNT_W > max(IMG_W, IMG_H)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  begin a frame; sampled only in IDLE
in_valid  in  1  upstream has a column (in_l1..in_l3) ready at the window inputs
in_ready  out  1  controller accepts a column this cycle
wr_sft_en  out  1  shift enable to the window register; = in_valid & in_ready
win_valid  out  1  window register holds a valid 3x3 neighbourhood
out_ready  in  1  downstream consumes the window this cycle when win_valid=1
col_cnt  out  CNT_W  columns shifted in the current row (0..IMG_W)
row_cnt  out  CNT_W  current output row index (0..IMG_H-3)
row_adv  out  1  one-cycle pulse: line buffers advance one line
frame_done  out  1  one-cycle pulse after last window consumed
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; col_cnt=0, row_cnt=0, win_valid=0, row_adv=0, frame_done=0, busy=0, in_ready=0, wr_sft_en=0. Reset mid-frame aborts immediately to IDLE with these values; window register contents are don't-care.
- States: IDLE, FILL, STREAM, ROW_END, DONE.
- IDLE: in_ready=0. start=1 -> FILL, col_cnt=0, row_cnt=0.
- FILL (col_cnt<2): in_ready=1. Each accepted column: col_cnt+1. At the second accept (col_cnt 1->2) -> STREAM. win_valid stays 0.
- STREAM: in_ready = (col_cnt<IMG_W) & (~win_valid | out_ready). Accept: col_cnt+1, win_valid<=1 next cycle (window data and flag appear together, 1 cycle after wr_sft_en). Consume without accept: win_valid<=0. Accept and consume in the same cycle: win_valid stays 1 (back-to-back, one window/cycle).
- Stall rule: win_valid=1 & out_ready=0 -> in_ready=0; window register never shifts over an unconsumed window.
- Row end: when col_cnt=IMG_W and win_valid=0 (last window consumed) -> ROW_END. No extra shifts beyond IMG_W per row.
- ROW_END (1 cycle): row_adv=1, col_cnt<=0. If row_cnt=IMG_H-3 -> DONE; else row_cnt+1, -> FILL.
- DONE (1 cycle): frame_done=1 -> IDLE. busy=0 from the next cycle.
- Windows per row = IMG_W-2; per frame = (IMG_W-2)*(IMG_H-2).
- start outside IDLE: ignored. in_valid in IDLE/ROW_END/DONE: ignored (in_ready=0).
- Counters never wrap within a frame; col_cnt saturates at IMG_W until ROW_END.
- row_adv and frame_done are registered outputs, never asserted together in one cycle.

Decomposition:
- Shared package: state encoding (IDLE..DONE), CNT_W default, shared BIT_DEPTH constant.
- One natural sub-module: pos_counter (col/row counters with terminal-count flags col_last, row_last). FSM, handshake and win_valid flag stay in window_ctrl.
- window_ctrl is instantiated beside the 3x3 window register; wr_sft_en drives its shift enable directly.

Test Plan:
- IMG_W=5, IMG_H=4, in_valid=1, out_ready=1 continuously, start pulse -> wr_sft_en 5 cycles per row, win_valid high 3 consecutive cycles per row, 2 row_adv pulses, 6 windows total, frame_done once, busy low after.
- Same config, out_ready=0 for 4 cycles on the first valid window -> in_ready=0 and wr_sft_en=0 throughout the stall; window outputs unchanged; window consumed after release; total still 6.
- Pixel values col k = {10k+1, 10k+2, 10k+3} -> first win_valid shows r1_col1=21, r1_col2=11, r1_col3=1; second shows 31/21/11.
- in_valid toggling 1/0 every cycle -> col_cnt advances only on accepts; win_valid count per row still 3; no shift while in_valid=0.
- rst=1 for one cycle mid-STREAM (row_cnt=1, col_cnt=3) -> next cycle IDLE, all outputs 0; new start yields a full 6-window frame.
- start asserted during STREAM and DONE -> ignored; exactly one frame_done per accepted start.
